// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 support blocks: default widths, memory
// read latency and the state encoding of the memory dump reader.
package mips32_pkg;

    localparam int ADDR_W_DFLT = 10;
    localparam int DATA_W_DFLT = 32;
    localparam int CNT_W_DFLT  = 11;

    // Synchronous data memory: read data appears one cycle after the strobe.
    localparam int MEM_RD_LAT = 1;

    // Enough buffering to cover the read latency plus the word being offered.
    localparam int BUF_DEPTH = MEM_RD_LAT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_e;

endpackage

// File: rtl/dump_skid_buf.sv
// Two-entry FIFO holding {addr,data} pairs returned by the memory until the
// consumer accepts them. Outputs read zero whenever the buffer is empty.
module dump_skid_buf
    import mips32_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occupancy
);

    logic [ADDR_W-1:0] addr_q [BUF_DEPTH];
    logic [ADDR_W-1:0] addr_d [BUF_DEPTH];
    logic [DATA_W-1:0] data_q [BUF_DEPTH];
    logic [DATA_W-1:0] data_d [BUF_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;

    assign do_pop     = pop && (count_q != 2'd0);
    assign head_valid = (count_q != 2'd0);
    assign head_addr  = head_valid ? addr_q[rd_ptr_q] : '0;
    assign head_data  = head_valid ? data_q[rd_ptr_q] : '0;
    assign occupancy  = count_q;

    // Write the pushed entry at the tail, advance the head on pop, track fill level.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    // Storage and pointer registers, emptied by reset.
    always_ff @(posedge clk1) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Reads a window of data memory after the pipeline halts (or on a start pulse)
// and streams {addr,data} over valid/ready, keeping a running checksum.
module mem_dump_reader
    import mips32_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              halted,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              halted_q, halted_d;

    logic              trigger;
    logic              pop;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [1:0]        buf_occ;
    logic [2:0]        slots_used;
    logic              slot_free;
    logic [CNT_W-1:0]  issued_next;

    assign trigger     = start | (halted & ~halted_q);
    assign pop         = buf_valid & out_ready;
    assign slots_used  = {1'b0, buf_occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign slot_free   = (slots_used < 3'(BUF_DEPTH));
    assign issued_next = issued_q + CNT_W'(1);

    assign mem_addr  = addr_q;
    assign out_valid = buf_valid;
    assign out_addr  = buf_addr;
    assign out_data  = buf_data;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign checksum  = checksum_q;

    dump_skid_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .clk1      (clk1),
        .reset     (reset),
        .push      (inflight_q),
        .push_addr (tag_q),
        .push_data (mem_rdata),
        .pop       (pop),
        .head_valid(buf_valid),
        .head_addr (buf_addr),
        .head_data (buf_data),
        .occupancy (buf_occ)
    );

    // Dump sequencing: accept a trigger when idle, issue reads while buffer
    // space is guaranteed, then wait for the consumer to take every word.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        issued_d   = issued_q;
        tag_d      = tag_q;
        done_d     = 1'b0;
        checksum_d = checksum_q;
        halted_d   = halted;
        mem_rd_en  = 1'b0;

        if (pop) begin
            checksum_d = checksum_q + buf_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    checksum_d = '0;
                    if (word_cnt != '0) begin
                        state_d  = ST_READ;
                        addr_d   = base_addr;
                        cnt_d    = word_cnt;
                        issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                mem_rd_en = (issued_q < cnt_q) && slot_free;
                if (mem_rd_en) begin
                    tag_d    = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_next;
                    if (issued_next == cnt_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && ((buf_occ == 2'd0) || ((buf_occ == 2'd1) && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inflight_d = mem_rd_en;
    end

    // Control and datapath registers; reset aborts any dump without a done pulse.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            checksum_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            checksum_q <= checksum_d;
            halted_q   <= halted_d;
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: a synchronous memory model, a
// scoreboard of expected {addr,data} words and a table of dump scenarios.
module tb_mem_dump_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 11;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [CNT_W-1:0]  cnt;
        int                readyMode;
        logic [DATA_W-1:0] expSum;
    } vec_t;

    logic              clk1;
    logic              reset;
    logic              halted;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    exp_t              expQ [$];

    int total = 0;
    int bad = 0;
    int cycleCount = 0;
    int readyMode = 0;
    int trigCycle = 0;
    int firstValidCycle = 0;
    int lastAcceptCycle = 0;
    int doneCycle = 0;
    int acceptCount = 0;
    bit firstSeen = 0;
    bit prevStall = 0;
    logic [ADDR_W-1:0] stallAddr;
    logic [DATA_W-1:0] stallData;

    vec_t vecs [5];

    mem_dump_reader dut (
        .clk1     (clk1),
        .reset    (reset),
        .halted   (halted),
        .start    (start),
        .base_addr(base_addr),
        .word_cnt (word_cnt),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        forever begin
            @(posedge clk1);
            cycleCount++;
        end
    end

    // Synchronous memory: data valid the cycle after the read strobe.
    always @(posedge clk1) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Consumer ready pattern: 0 always, 1 toggling, 2 random, 3 driven by hand.
    initial begin
        forever begin
            @(posedge clk1);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Output monitor: scoreboard compare on accept, stability check while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1);
            if (!reset) begin
                if (prevStall) begin
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_addr", 32'(out_addr), 32'(stallAddr));
                    checkOutput("stall_data", out_data, stallData);
                end
                if (out_valid && !firstSeen) begin
                    firstSeen = 1'b1;
                    firstValidCycle = cycleCount;
                end
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_word: got addr %0d data %0d expected none", out_addr, out_data);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("word_addr", 32'(out_addr), 32'(e.addr));
                        checkOutput("word_data", out_data, e.data);
                    end
                    lastAcceptCycle = cycleCount;
                    acceptCount++;
                end
                prevStall = out_valid && !out_ready;
                stallAddr = out_addr;
                stallData = out_data;
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    task automatic pushExpected(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        exp_t e;
        for (int i = 0; i < int'(cnt); i++) begin
            e.addr = base + ADDR_W'(i);
            e.data = mem[e.addr];
            expQ.push_back(e);
        end
    endtask

    // One complete dump: trigger, wait (bounded) for done, then check results and idleness.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                                 input int mode, input logic [DATA_W-1:0] expSum,
                                 input bit useStart, input bit useHalted);
        bit gotDone;
        bit sawBusy;
        readyMode = mode;
        pushExpected(base, cnt);
        firstSeen = 1'b0;
        acceptCount = 0;
        @(posedge clk1);
        #1;
        start = useStart;
        if (useHalted) halted = 1'b1;
        base_addr = base;
        word_cnt = cnt;
        trigCycle = cycleCount;
        @(posedge clk1);
        #1;
        start = 1'b0;
        checkOutput("busy_after_trigger", 32'(busy), 32'd1);
        gotDone = 1'b0;
        for (int c = 0; c < 300 && !gotDone; c++) begin
            @(negedge clk1);
            if (done) begin
                gotDone = 1'b1;
                doneCycle = cycleCount;
            end
        end
        if (!gotDone) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done expected done within 300 cycles");
            expQ.delete();
        end else begin
            checkOutput("words_left", 32'(expQ.size()), 32'd0);
            checkOutput("accept_count", 32'(acceptCount), 32'(cnt));
            checkOutput("busy_at_done", 32'(busy), 32'd0);
            checkOutput("checksum", checksum, expSum);
            checkOutput("done_after_last", 32'(doneCycle), 32'(lastAcceptCycle + 1));
            checkOutput("first_valid_latency", 32'(firstValidCycle), 32'(trigCycle + 3));
            if (mode == 0) begin
                checkOutput("back_to_back", 32'(lastAcceptCycle - firstValidCycle), 32'(cnt) - 32'd1);
            end
            @(negedge clk1);
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            sawBusy = 1'b0;
            repeat (20) begin
                @(negedge clk1);
                if (busy || mem_rd_en) sawBusy = 1'b1;
            end
            checkOutput("no_retrigger", 32'(sawBusy), 32'd0);
            checkOutput("checksum_hold", checksum, expSum);
        end
    endtask

    initial begin
        bit sawAct;
        bit sawDone;
        bit gotAccept;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'(i * 7 + 3);
        mem[120] = 32'd85;
        mem[121] = 32'd130;

        vecs[0] = '{base: 10'd120,  cnt: 11'd2, readyMode: 0, expSum: 32'd215};
        vecs[1] = '{base: 10'd120,  cnt: 11'd2, readyMode: 1, expSum: 32'd215};
        vecs[2] = '{base: 10'd1022, cnt: 11'd4, readyMode: 0, expSum: 32'd14334};
        vecs[3] = '{base: 10'd5,    cnt: 11'd3, readyMode: 2, expSum: 32'd135};
        vecs[4] = '{base: 10'd0,    cnt: 11'd8, readyMode: 1, expSum: 32'd220};

        reset = 1'b1;
        halted = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_cnt = '0;
        out_ready = 1'b1;
        mem_rdata = '0;
        repeat (3) @(posedge clk1);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_checksum", checksum, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk1);

        $display("[TB] table-driven dumps");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].base, vecs[v].cnt, vecs[v].readyMode, vecs[v].expSum, 1'b1, 1'b0);
        end

        $display("[TB] start coincident with halted edge");
        applyStimulus(10'd120, 11'd2, 0, 32'd215, 1'b1, 1'b1);
        halted = 1'b0;
        repeat (3) @(posedge clk1);

        $display("[TB] halted edge dump, halted held high");
        applyStimulus(10'd0, 11'd8, 0, 32'd220, 1'b0, 1'b1);
        sawAct = 1'b0;
        repeat (100) begin
            @(negedge clk1);
            if (busy || mem_rd_en || out_valid) sawAct = 1'b1;
        end
        checkOutput("halted_held_no_dump", 32'(sawAct), 32'd0);
        halted = 1'b0;
        repeat (2) @(posedge clk1);

        $display("[TB] zero-count start");
        @(posedge clk1);
        #1;
        start = 1'b1;
        base_addr = 10'd50;
        word_cnt = '0;
        @(posedge clk1);
        #1;
        start = 1'b0;
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        checkOutput("zero_checksum", checksum, 32'd0);
        sawAct = 1'b0;
        sawDone = 1'b0;
        repeat (6) begin
            @(posedge clk1);
            #1;
            if (mem_rd_en || out_valid || busy) sawAct = 1'b1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("zero_no_activity", 32'(sawAct), 32'd0);
        checkOutput("zero_done_single", 32'(sawDone), 32'd0);

        $display("[TB] reset mid-dump");
        readyMode = 3;
        out_ready = 1'b1;
        firstSeen = 1'b0;
        acceptCount = 0;
        pushExpected(10'd10, 11'd4);
        @(posedge clk1);
        #1;
        start = 1'b1;
        base_addr = 10'd10;
        word_cnt = 11'd4;
        @(posedge clk1);
        #1;
        start = 1'b0;
        gotAccept = 1'b0;
        for (int c = 0; c < 50 && !gotAccept; c++) begin
            @(posedge clk1);
            #1;
            if (acceptCount >= 1) gotAccept = 1'b1;
        end
        checkOutput("mid_first_accept", 32'(gotAccept), 32'd1);
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk1);
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out_addr", 32'(out_addr), 32'd0);
        checkOutput("mid_rst_out_data", out_data, 32'd0);
        checkOutput("mid_rst_checksum", checksum, 32'd0);
        expQ.delete();
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (5) begin
            @(posedge clk1);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("mid_rst_no_done", 32'(sawDone), 32'd0);
        applyStimulus(10'd10, 11'd4, 0, 32'd334, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
